// File: rtl/seg_step_sequencer_pkg.sv
// Shared types, pattern ROM and rate decoding for the segment step sequencer.
package seg_seq_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } seq_state_e;

  // Decimal glyphs 0..7, bit order gfedcba.
  localparam logic [6:0] PATTERN_ROM [8] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
  };

  // Terminal prescaler value (divisor minus one) for each rate selection.
  function automatic logic [15:0] rate_divisor(input logic [1:0] rate_sel);
    logic [15:0] term;
    case (rate_sel)
      2'd0:    term = 16'h000F;
      2'd1:    term = 16'h00FF;
      2'd2:    term = 16'h0FFF;
      default: term = 16'hFFFF;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/seg_step_sequencer_if.sv
// Control inputs and display outputs of the segment step sequencer.
interface seg_step_sequencer_if;

  logic       run;
  logic       step;
  logic       dir_down;
  logic [1:0] rate_sel;
  logic [2:0] step_idx;
  logic [6:0] segments;
  logic       wrap_tgl;

  // Driver side: the wrapper or bench that controls the sequencer.
  modport master (
    output run, step, dir_down, rate_sel,
    input  step_idx, segments, wrap_tgl
  );

  // Sequencer side.
  modport slave (
    input  run, step, dir_down, rate_sel,
    output step_idx, segments, wrap_tgl
  );

endinterface

// File: rtl/seg_step_sequencer_prescaler.sv
// Single-clock prescaler: counts 0..terminal while enabled and flags the terminal cycle.
module seg_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] terminal_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;

  assign tick_o = enable_i & ~clear_i & (cnt_q == terminal_i);

  // Count up while enabled, wrap to zero at the terminal value, clear has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      if (cnt_q >= terminal_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_step_sequencer.sv
// Run/stop/single-step controller stepping a 3-bit index through the 7-segment pattern ROM.
// PRESCALE_W must be at least 16 so the slowest divisor fits.
module seg_step_sequencer
  import seg_seq_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  seg_step_sequencer_if.slave bus
);

  seq_state_e state_q;
  logic       step_q;
  logic [1:0] rate_q;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [6:0] seg_q;
  logic       wrap_q;
  logic       wrap_d;

  logic                  step_rise;
  logic                  rate_change;
  logic                  run_active;
  logic                  presc_clear;
  logic                  tick;
  logic                  advance;
  logic [PRESCALE_W-1:0] terminal;

  assign step_rise   = bus.step & ~step_q;
  assign rate_change = (bus.rate_sel != rate_q);
  assign run_active  = (state_q == RUN) && bus.run;
  assign presc_clear = ~run_active | rate_change;
  assign terminal    = PRESCALE_W'(rate_divisor(rate_q));
  assign advance     = (tick | (state_q == STEP)) & ~rate_change;

  seg_prescaler #(
    .W(PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (presc_clear),
    .enable_i   (run_active),
    .terminal_i (terminal),
    .tick_o     (tick)
  );

  // Next index and wrap detection; direction only matters on advancing edges.
  always_comb begin
    idx_d  = idx_q + 3'd1;
    wrap_d = (idx_q == 3'd7);
    if (bus.dir_down) begin
      idx_d  = idx_q - 3'd1;
      wrap_d = (idx_q == 3'd0);
    end
  end

  // Control FSM plus registered index, segment and wrap outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STOP;
      step_q  <= 1'b0;
      rate_q  <= 2'd0;
      idx_q   <= 3'd0;
      seg_q   <= 7'h3F;
      wrap_q  <= 1'b0;
    end else begin
      step_q <= bus.step;
      rate_q <= bus.rate_sel;
      case (state_q)
        STOP: begin
          if (bus.run) begin
            state_q <= RUN;
          end else if (step_rise) begin
            state_q <= STEP;
          end
        end
        RUN: begin
          if (!bus.run) begin
            state_q <= STOP;
          end
        end
        STEP:    state_q <= STOP;
        default: state_q <= STOP;
      endcase
      if (advance) begin
        idx_q <= idx_d;
        seg_q <= PATTERN_ROM[idx_d];
        if (wrap_d) begin
          wrap_q <= ~wrap_q;
        end
      end
    end
  end

  assign bus.step_idx = idx_q;
  assign bus.segments = seg_q;
  assign bus.wrap_tgl = wrap_q;

endmodule

// File: tb/tb_seg_step_sequencer.sv
// Directed scoreboard bench for the segment step sequencer.
module tb_seg_step_sequencer;

  typedef struct {
    string      tag;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  localparam logic [6:0] GLYPH [8] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
  };

  logic clk;
  logic reset;
  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;

  seg_step_sequencer_if bus ();

  seg_step_sequencer #(
    .PRESCALE_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic s, input logic d, input logic [1:0] rs);
    bus.run      = r;
    bus.step     = s;
    bus.dir_down = d;
    bus.rate_sel = rs;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushExpect(input string tag, input logic [2:0] idx, input logic wrap);
    exp_t e;
    e.tag  = tag;
    e.idx  = idx;
    e.wrap = wrap;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [10:0] obs;
    logic [10:0] expv;
    checks++;
    if (sbQueue.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: nothing expected, observed idx=%0d", bus.step_idx);
    end else begin
      e    = sbQueue.pop_front();
      expv = {e.idx, GLYPH[e.idx], e.wrap};
      obs  = {bus.step_idx, bus.segments, bus.wrap_tgl};
      assert (obs === expv) else begin
        errors++;
        $error("[TB] FAIL %s: observed idx=%0d seg=%h wrap=%b, expected idx=%0d seg=%h wrap=%b",
               e.tag, bus.step_idx, bus.segments, bus.wrap_tgl, e.idx, GLYPH[e.idx], e.wrap);
      end
    end
  endtask

  task automatic expectNow(input string tag, input logic [2:0] idx, input logic wrap);
    pushExpect(tag, idx, wrap);
    checkOutput();
  endtask

  // Directed sequence; inputs change and outputs are sampled on the falling edge.
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    waitEdges(2);
    reset = 1'b0;
    expectNow("reset", 3'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      waitEdges(1);
      expectNow("idle", 3'd0, 1'b0);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    waitEdges(1);
    expectNow("run-E0", 3'd0, 1'b0);
    waitEdges(15);
    expectNow("run-E15", 3'd0, 1'b0);
    waitEdges(1);
    expectNow("run-E16", 3'd1, 1'b0);
    waitEdges(15);
    expectNow("run-E31", 3'd1, 1'b0);
    waitEdges(1);
    expectNow("run-E32", 3'd2, 1'b0);
    waitEdges(80);
    expectNow("run-idx7", 3'd7, 1'b0);
    waitEdges(16);
    expectNow("wrap-up", 3'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0);
    waitEdges(16);
    expectNow("wrap-down", 3'd7, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    waitEdges(1);
    expectNow("stop", 3'd7, 1'b0);
    waitEdges(20);
    expectNow("stop-hold", 3'd7, 1'b0);
    reset = 1'b1;
    waitEdges(1);
    reset = 1'b0;
    expectNow("reset-stop", 3'd0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    waitEdges(1);
    expectNow("step1-E", 3'd0, 1'b0);
    waitEdges(1);
    expectNow("step1-E1", 3'd1, 1'b0);
    waitEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    expectNow("step1-held", 3'd1, 1'b0);
    waitEdges(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    waitEdges(1);
    expectNow("step2-E", 3'd1, 1'b0);
    waitEdges(1);
    expectNow("step2-E1", 3'd2, 1'b0);
    waitEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    waitEdges(3);
    expectNow("step2-after", 3'd2, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    waitEdges(1);
    expectNow("run-beats-step", 3'd2, 1'b0);
    waitEdges(1);
    expectNow("run-beats-step-E1", 3'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    waitEdges(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    waitEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    waitEdges(10);
    expectNow("step-in-run-E15", 3'd2, 1'b0);
    waitEdges(1);
    expectNow("step-in-run-E16", 3'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    waitEdges(1);
    expectNow("stop2", 3'd3, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1);
    waitEdges(1);
    waitEdges(200);
    expectNow("rate1-200", 3'd3, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    waitEdges(1);
    expectNow("rate-change", 3'd3, 1'b0);
    waitEdges(15);
    expectNow("rate-change-15", 3'd3, 1'b0);
    waitEdges(1);
    expectNow("rate-change-16", 3'd4, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0);
    waitEdges(112);
    expectNow("down-to-5", 3'd5, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
    waitEdges(1);
    reset = 1'b0;
    expectNow("reset-in-run", 3'd0, 1'b0);
    waitEdges(20);
    expectNow("post-reset-hold", 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0);
    waitEdges(16);
    expectNow("rerun-E15", 3'd0, 1'b0);
    waitEdges(1);
    expectNow("rerun-E16", 3'd7, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
